// File: rtl/if_instr_queue.sv
// Instruction fetch queue: buffers words returned by the instruction cache
// (instruction, PC, fetch exception bits, prediction) and presents the oldest
// one, show-ahead, to the ID-stage pipeline register.
module if_instr_queue #(
  parameter int DEPTH  = 8,
  parameter int EXC_W  = 16,
  parameter int PRED_W = 34
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       IF_Flush,
  input  logic                       Fetch_Valid,
  input  logic [31:0]                Fetch_Instr,
  input  logic [31:0]                Fetch_PC,
  input  logic [EXC_W-1:0]           Fetch_ExceptType,
  input  logic [PRED_W-1:0]          Fetch_PResult,
  output logic                       Fetch_Ready,
  input  logic                       ID_Wr,
  output logic                       IF_Valid,
  output logic [31:0]                IF_Instr,
  output logic [31:0]                IF_PC,
  output logic [EXC_W-1:0]           IF_ExceptType,
  output logic [PRED_W-1:0]          IF_PResult,
  output logic [$clog2(DEPTH+1)-1:0] Queue_Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Payload storage; never reset, validity is tracked by the occupancy count.
  logic [31:0]       instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];
  logic [EXC_W-1:0]  exc_mem   [DEPTH];
  logic [PRED_W-1:0] pred_mem  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // A full queue refuses a push even when a pop happens in the same cycle,
  // so Fetch_Ready depends on the count only (no combinational path from ID_Wr).
  assign Fetch_Ready = (count != CW'(DEPTH));
  assign IF_Valid    = (count != '0);
  assign Queue_Count = count;

  // Flush dominates: neither a push nor a pop is honoured in a flush cycle.
  assign push = Fetch_Valid & Fetch_Ready & ~IF_Flush;
  assign pop  = ID_Wr & IF_Valid & ~IF_Flush;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (IF_Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Write the fetched word at the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= Fetch_Instr;
      pc_mem[tail]    <= Fetch_PC;
      exc_mem[tail]   <= Fetch_ExceptType;
      pred_mem[tail]  <= Fetch_PResult;
    end
  end

  // Show-ahead head outputs; an empty queue presents an all-zero NOP bubble.
  always_comb begin
    IF_Instr      = '0;
    IF_PC         = '0;
    IF_ExceptType = '0;
    IF_PResult    = '0;
    if (IF_Valid) begin
      IF_Instr      = instr_mem[head];
      IF_PC         = pc_mem[head];
      IF_ExceptType = exc_mem[head];
      IF_PResult    = pred_mem[head];
    end
  end

endmodule

// File: doc/if_instr_queue.md
# if_instr_queue

Instruction fetch queue that forms the producing end of the IF→ID interface. It buffers fetched instruction words, each with its PC, fetch exception bits and branch-prediction result, as they return from the instruction cache. It presents the oldest entry to the ID-stage pipeline register and pops it whenever ID accepts. It decouples cache return timing from ID stalls, back-pressures fetch when full, and is emptied by pipeline flush/redirect.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- EXC_W, 16, width of packed fetch exception field (ExceptinPipeType bits)
- PRED_W, 34, width of packed prediction result (includes 32-bit Target)
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- IF_Flush  in  1  discard all entries (redirect/exception); dominant over push/pop
- Fetch_Valid  in  1  cache returns a fetched word this cycle
- Fetch_Instr  in  32  fetched instruction
- Fetch_PC  in  32  PC of fetched instruction
- Fetch_ExceptType  in  EXC_W  fetch-side exception bits
- Fetch_PResult  in  PRED_W  prediction result for this PC
- Fetch_Ready  out  1  queue can accept (not full)
- ID_Wr  in  1  ID register accepts the presented entry this cycle
- IF_Valid  out  1  head entry is valid
- IF_Instr  out  32  head instruction; 32'h0 (NOP) when empty
- IF_PC  out  32  head PC; 0 when empty
- IF_ExceptType  out  EXC_W  head exception bits; 0 when empty
- IF_PResult  out  PRED_W  head prediction; 0 when empty
- Queue_Count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Storage: DEPTH-entry circular buffer; fields {Instr, PC, ExceptType, PResult}; head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; separate occupancy counter.
- Push = Fetch_Valid & Fetch_Ready & ~IF_Flush; writes entry at tail, tail+1.
- Pop = ID_Wr & IF_Valid & ~IF_Flush; head+1.
- Fetch_Ready = (Queue_Count != DEPTH). Full queue does not accept push even if pop occurs same cycle (no pass-through on full); Fetch_Valid with Fetch_Ready=0 is dropped, and the fetch unit must hold/replay it.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
- Empty: IF_Valid=0, all payload outputs 0 (ID latches a NOP bubble); ID_Wr ignored, so no underflow.
- Head outputs are show-ahead, driven combinationally from the head entry and count. No bypass: a word pushed into an empty queue appears on IF_* the following cycle.
- IF_Flush: head, tail and count all go to 0 at the next edge; same-cycle push and pop are ignored. Entry payload RAM need not be cleared.
- ID_Wr=0 (ID stall): head held stable, outputs unchanged, push continues until full.
- Exception entries (nonzero ExceptType) queue and pop like any other entry; Instr is passed through untouched.

## Timing
- Reset (async assert, sync-free release): head=tail=0, count=0 → Fetch_Ready=1, IF_Valid=0, IF_Instr/IF_PC/IF_ExceptType/IF_PResult=0, Queue_Count=0.
- Push→visible latency: 1 cycle. Pop takes effect at the edge where ID_Wr=1 and the next entry is presented in the same cycle after that edge.
- Throughput: 1 push + 1 pop per cycle sustained.
- Fetch_Ready deasserts in the cycle after the push that fills the queue. It reasserts in the cycle after the first pop from full.
- Flush→Fetch_Ready=1, IF_Valid=0 in the cycle after the flush edge.
- Reset mid-operation: immediate return to reset values regardless of clk.

## Test plan
- Reset then idle: rst=1 for 3 cycles with Fetch_Valid=1 → IF_Valid=0, IF_Instr=0, Queue_Count=0, Fetch_Ready=1 throughout reset.
- Fill/drain: ID_Wr=0, push 8 words PC=0xBFC00000+4i, Instr=0x24000000+i → count reaches 8, Fetch_Ready=0; a 9th push is dropped. Then ID_Wr=1 for 8 cycles → IF_PC sequence 0xBFC00000..0xBFC0001C in order, then IF_Valid=0 and IF_Instr=0.
- Streaming: push and pop every cycle for 20 cycles starting empty → count stays 1 after the first cycle, and IF_PC advances by 4 each cycle with 1-cycle latency.
- Wrap-around: push 6, pop 6, then push 8 → pointers wrap, all 8 read back in order with correct ExceptType/PResult (e.g. entry 3 ExceptType=0x0004, PResult target 0x80001000).
- Flush with simultaneous push/pop at count=5 → next cycle count=0, IF_Valid=0, and the pushed word is absent; a subsequent push of PC=0x80002000 appears as head one cycle later.
- Full with pop and push same cycle → pop accepted, push rejected, count 7, Fetch_Ready=1 next cycle.
